pc_stack_unit: RTL and testbench

Parametrised program-counter unit for the control path: generates the instruction address each cycle and supports sequential increment, absolute and PC-relative jumps, and subroutine call/return through an internal return-address stack. It sits between instruction decode (enables, target) and instruction memory (address), and extends the plain counter with configurable width, reset vector, stall, and stack overflow/underflow detection.

---
 rtl/pc_pkg.sv | 15 +
 rtl/ret_stack.sv | 51 +++++
 rtl/pc_stack_unit.sv | 99 +++++++++
 tb/tb_pc_stack_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter path: next-PC select codes
// and the default reset vector, also used by instruction decode.
package pc_pkg;

   typedef enum logic [2:0] {
      SEL_INC,
      SEL_JMP,
      SEL_CALL,
      SEL_RET,
      SEL_HOLD
   } pc_sel_t;

   localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0;

endpackage

// File: rtl/ret_stack.sv
// Return-address stack: DEPTH entries of AW bits, occupancy counter sp,
// full/empty status. Push and pop are requested by the PC unit; a pop
// wins over a push, and requests that would over/underflow are dropped.
module ret_stack #(
   parameter int AW    = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [AW-1:0]          push_data,
   output logic [AW-1:0]          top_data,
   output logic [$clog2(DEPTH):0] sp,
   output logic                   full,
   output logic                   empty
);

   localparam int IW = $clog2(DEPTH);

   logic [AW-1:0] mem [DEPTH];
   logic [IW-1:0] wr_idx;
   logic [IW-1:0] top_idx;
   logic          do_push;
   logic          do_pop;

   assign full    = (sp == (IW+1)'(DEPTH));
   assign empty   = (sp == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && !pop && !full;

   // Slot indices; when full the low bits of sp are zero, so top_idx wraps to DEPTH-1.
   assign wr_idx   = sp[IW-1:0];
   assign top_idx  = sp[IW-1:0] - IW'(1);
   assign top_data = mem[top_idx];

   // Entry storage, written on the falling edge alongside the PC.
   // NOTE: the array has no reset -- only sp is cleared, which makes every
   // entry unreachable, and leaving memories unreset lets them map to RAM.
   always_ff @(negedge clk) begin
      if (do_push) mem[wr_idx] <= push_data;
   end

   // Occupancy counter; reset discards the whole stack at once.
   always_ff @(negedge clk or posedge rst) begin
      if (rst)          sp <= '0;
      else if (do_pop)  sp <= sp - (IW+1)'(1);
      else if (do_push) sp <= sp + (IW+1)'(1);
   end

endmodule

// File: rtl/pc_stack_unit.sv
// Program-counter unit: sequential increment, absolute/relative jumps and
// call/return through ret_stack. All state moves on the falling edge so the
// instruction memory sees a settled address at its next rising edge.
module pc_stack_unit
   import pc_pkg::*;
#(
   parameter int            AW        = 8,
   parameter int            DEPTH     = 4,
   parameter logic [AW-1:0] RESET_VEC = AW'(DEFAULT_RESET_VEC)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall,
   input  logic                   jmp_en,
   input  logic                   jmp_rel,
   input  logic [AW-1:0]          jmp_addr,
   input  logic                   call_en,
   input  logic                   ret_en,
   output logic [AW-1:0]          pc,
   output logic [$clog2(DEPTH):0] sp,
   output logic                   stack_ovf,
   output logic                   stack_unf
);

   pc_sel_t       sel;
   logic [AW-1:0] pc_inc;
   logic [AW-1:0] target;
   logic [AW-1:0] pc_next;
   logic [AW-1:0] ret_addr;
   logic          full;
   logic          empty;
   logic          ovf_set;
   logic          unf_set;

   assign pc_inc = pc + AW'(1);
   assign target = jmp_rel ? (pc + jmp_addr) : jmp_addr;

   // A faulting call/return holds the PC and raises its sticky flag.
   assign ovf_set = !stall && !ret_en && call_en && full;
   assign unf_set = !stall && ret_en && empty;

   // Next-PC source, priority stall > ret > call > jmp > increment.
   // NOTE: sel gets a default before any branch so no path leaves it
   // unassigned -- otherwise synthesis infers a latch.
   always_comb begin
      sel = SEL_INC;
      if (stall)        sel = SEL_HOLD;
      else if (ret_en)  sel = empty ? SEL_HOLD : SEL_RET;
      else if (call_en) sel = full ? SEL_HOLD : SEL_CALL;
      else if (jmp_en)  sel = SEL_JMP;
   end

   // Next-PC mux driven by the select code.
   always_comb begin
      pc_next = pc_inc;
      case (sel)
         SEL_JMP,
         SEL_CALL: pc_next = target;
         SEL_RET:  pc_next = ret_addr;
         SEL_HOLD: pc_next = pc;
         default:  pc_next = pc_inc;
      endcase
   end

   ret_stack #(
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_ret_stack (
      .clk       (clk),
      .rst       (rst),
      .push      (sel == SEL_CALL),
      .pop       (sel == SEL_RET),
      .push_data (pc_inc),
      .top_data  (ret_addr),
      .sp        (sp),
      .full      (full),
      .empty     (empty)
   );

   // PC register, loaded with the reset vector asynchronously.
   // NOTE: registers use non-blocking assignment so every flop samples the
   // pre-edge values of its neighbours, matching real hardware.
   always_ff @(negedge clk or posedge rst) begin
      if (rst) pc <= RESET_VEC;
      else     pc <= pc_next;
   end

   // Sticky fault flags, cleared only by reset.
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         stack_ovf <= 1'b0;
         stack_unf <= 1'b0;
      end else begin
         if (ovf_set) stack_ovf <= 1'b1;
         if (unf_set) stack_unf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit (AW=8, DEPTH=4, RESET_VEC=0x10).
// Each step drives inputs, queues the expected state, and after the next
// falling edge pops the expectation and compares it with the outputs.
module tb_pc_stack_unit;

   logic       clk;
   logic       rst;
   logic       stall;
   logic       jmp_en;
   logic       jmp_rel;
   logic [7:0] jmp_addr;
   logic       call_en;
   logic       ret_en;
   logic [7:0] pc;
   logic [2:0] sp;
   logic       stack_ovf;
   logic       stack_unf;

   typedef struct {
      logic [7:0] pc;
      logic [2:0] sp;
      logic       ovf;
      logic       unf;
   } exp_t;

   exp_t sb[$];
   int   vectors;
   int   miscompares;

   pc_stack_unit #(
      .AW        (8),
      .DEPTH     (4),
      .RESET_VEC (8'h10)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall),
      .jmp_en    (jmp_en),
      .jmp_rel   (jmp_rel),
      .jmp_addr  (jmp_addr),
      .call_en   (call_en),
      .ret_en    (ret_en),
      .pc        (pc),
      .sp        (sp),
      .stack_ovf (stack_ovf),
      .stack_unf (stack_unf)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic compare_front(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         check({tag, "/sb_empty"}, 8'd1, 8'd0);
      end else begin
         e = sb.pop_front();
         check({tag, "/pc"},  pc,                e.pc);
         check({tag, "/sp"},  {5'd0, sp},        {5'd0, e.sp});
         check({tag, "/ovf"}, {7'd0, stack_ovf}, {7'd0, e.ovf});
         check({tag, "/unf"}, {7'd0, stack_unf}, {7'd0, e.unf});
      end
   endtask

   task automatic idle_inputs();
      stall    = 1'b0;
      jmp_en   = 1'b0;
      jmp_rel  = 1'b0;
      jmp_addr = 8'h00;
      call_en  = 1'b0;
      ret_en   = 1'b0;
   endtask

   // Drive one set of inputs, expect the given state after the next falling edge.
   task automatic step(input logic s, input logic j, input logic r, input logic [7:0] a,
                       input logic c, input logic rt, input logic [7:0] e_pc,
                       input logic [2:0] e_sp, input logic e_o, input logic e_u,
                       input string tag);
      exp_t e;
      stall    = s;
      jmp_en   = j;
      jmp_rel  = r;
      jmp_addr = a;
      call_en  = c;
      ret_en   = rt;
      e.pc = e_pc; e.sp = e_sp; e.ovf = e_o; e.unf = e_u;
      sb.push_back(e);
      @(negedge clk);
      #1;
      compare_front(tag);
   endtask

   // Reset pulse mid-cycle: checked immediately, then held across a falling edge.
   task automatic reset_pulse(input string tag);
      exp_t e;
      e.pc = 8'h10; e.sp = 3'd0; e.ovf = 1'b0; e.unf = 1'b0;
      idle_inputs();
      #2;
      rst = 1'b1;
      sb.push_back(e);
      #1;
      compare_front({tag, "_async"});
      sb.push_back(e);
      @(negedge clk);
      #1;
      compare_front({tag, "_held"});
      #2;
      rst = 1'b0;
   endtask

   initial begin
      exp_t e;
      vectors     = 0;
      miscompares = 0;
      idle_inputs();
      rst = 1'b1;
      e.pc = 8'h10; e.sp = 3'd0; e.ovf = 1'b0; e.unf = 1'b0;
      sb.push_back(e);
      #1;
      compare_front("por");
      @(negedge clk);
      #1;
      rst = 1'b0;

      // Reset and increment
      step(0,0,0,8'h00,0,0, 8'h11,3'd0,0,0, "inc0");
      reset_pulse("rst1");
      step(0,0,0,8'h00,0,0, 8'h11,3'd0,0,0, "inc1");
      step(0,0,0,8'h00,0,0, 8'h12,3'd0,0,0, "inc2");
      step(0,0,0,8'h00,0,0, 8'h13,3'd0,0,0, "inc3");

      // Wrap and relative jump
      step(0,1,0,8'hFE,0,0, 8'hFE,3'd0,0,0, "jmp_fe");
      step(0,0,0,8'h00,0,0, 8'hFF,3'd0,0,0, "inc_ff");
      step(0,0,0,8'h00,0,0, 8'h00,3'd0,0,0, "wrap_00");
      step(0,1,0,8'h05,0,0, 8'h05,3'd0,0,0, "jmp_05");
      step(0,1,1,8'hFB,0,0, 8'h00,3'd0,0,0, "jrel_m5");

      // Nested call/return
      step(0,1,0,8'h20,0,0, 8'h20,3'd0,0,0, "jmp_20");
      step(0,0,0,8'h40,1,0, 8'h40,3'd1,0,0, "call_40");
      step(0,0,0,8'h60,1,0, 8'h60,3'd2,0,0, "call_60");
      step(0,0,0,8'h00,0,1, 8'h41,3'd1,0,0, "ret_41");
      step(0,0,0,8'h00,0,1, 8'h21,3'd0,0,0, "ret_21");
      step(0,0,1,8'h10,1,0, 8'h31,3'd1,0,0, "call_rel");
      step(0,0,0,8'h00,0,1, 8'h22,3'd0,0,0, "ret_22");

      // Overflow, stall, drain, underflow
      step(0,0,0,8'h80,1,0, 8'h80,3'd1,0,0, "call_80");
      step(0,0,0,8'h90,1,0, 8'h90,3'd2,0,0, "call_90");
      step(0,0,0,8'hA0,1,0, 8'hA0,3'd3,0,0, "call_a0");
      step(0,0,0,8'hB0,1,0, 8'hB0,3'd4,0,0, "call_b0");
      step(0,0,0,8'hC0,1,0, 8'hB0,3'd4,1,0, "call_ovf");
      step(1,0,0,8'hC0,1,0, 8'hB0,3'd4,1,0, "stall1");
      step(1,1,0,8'hC0,1,0, 8'hB0,3'd4,1,0, "stall2");
      step(1,0,0,8'h00,0,1, 8'hB0,3'd4,1,0, "stall3");
      step(0,0,0,8'h00,0,1, 8'hA1,3'd3,1,0, "ret_a1");
      step(0,0,0,8'h00,0,1, 8'h91,3'd2,1,0, "ret_91");
      step(0,0,0,8'h00,0,1, 8'h81,3'd1,1,0, "ret_81");
      step(0,0,0,8'h00,0,1, 8'h23,3'd0,1,0, "ret_23");
      step(0,0,0,8'h00,0,1, 8'h23,3'd0,1,1, "ret_unf");
      step(0,0,0,8'h00,0,0, 8'h24,3'd0,1,1, "sticky");
      reset_pulse("rst2");

      // Call and return together: pop only
      step(0,0,0,8'h50,1,0, 8'h50,3'd1,0,0, "call_50");
      step(0,1,0,8'h70,1,1, 8'h11,3'd0,0,0, "call_ret");

      // Reset during nesting discards the stack
      step(0,0,0,8'h30,1,0, 8'h30,3'd1,0,0, "nest1");
      step(0,0,0,8'h40,1,0, 8'h40,3'd2,0,0, "nest2");
      step(0,0,0,8'h50,1,0, 8'h50,3'd3,0,0, "nest3");
      reset_pulse("rst3");
      step(0,0,0,8'h00,0,1, 8'h10,3'd0,0,1, "ret_after_rst");
      step(0,0,0,8'h00,0,0, 8'h11,3'd0,0,1, "inc_after_unf");

      check("sb_drain", 8'(sb.size()), 8'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
